// File: rtl/fc1_engine.sv
// fc1 layer engine: sweeps the conv2 feature store through one signed MAC per neuron,
// then applies ReLU, an arithmetic shift and saturation before a valid/ready output.
module fc1_engine #(
  parameter int FEAT_DEPTH = 32,
  parameter int NUM_CH     = 16,
  parameter int OUT_N      = 10,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 24,
  parameter int OUT_SHIFT  = 4,
  localparam int W_AW = $clog2(OUT_N * FEAT_DEPTH * NUM_CH),
  localparam int N_W  = $clog2(OUT_N),
  localparam int A_W  = $clog2(FEAT_DEPTH),
  localparam int C_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              bram_en,
  output logic [10:0]       bram_addr,
  output logic [5:0]        ch_sel,
  input  logic [DATA_W-1:0] feat_in,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [N_W-1:0]    b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [N_W-1:0]    out_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  state_t r_state, w_state_nxt;

  logic [A_W-1:0]  r_a;
  logic [C_W-1:0]  r_c;
  logic [W_AW-1:0] r_w;
  logic [N_W-1:0]  r_n;
  logic            r_drain;

  logic w_issue, w_last_issue, w_accept, w_last_neuron;

  logic                       vld_p1, vld_p2, r_bias_p1;
  logic [C_W-1:0]             r_ch_p1;
  logic signed [2*DATA_W-1:0] r_prod_p2;
  logic signed [ACC_W-1:0]    r_acc, w_acc_nxt;
  logic [DATA_W-1:0]          r_out_data;
  logic [N_W-1:0]             r_out_idx;

  function automatic logic [DATA_W-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> OUT_SHIFT;
    if (v < 0)
      return '0;
    else if (s > SAT_MAX)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else
      return s[DATA_W-1:0];
  endfunction

  assign w_issue       = (r_state == S_RUN);
  assign w_last_issue  = w_issue && (r_a == A_W'(FEAT_DEPTH - 1)) && (r_c == C_W'(NUM_CH - 1));
  assign w_accept      = (r_state == S_OUT) && out_ready;
  assign w_last_neuron = (r_n == N_W'(OUT_N - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_BIAS;
      S_BIAS:  w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain) w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = w_last_neuron ? S_DONE : S_BIAS;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep counters: address outer, channel inner; address holds after the final issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_c     <= '0;
      r_w     <= '0;
      r_n     <= '0;
      r_drain <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_n <= '0;
        r_w <= '0;
      end
      if (r_state == S_BIAS) begin
        r_a     <= '0;
        r_c     <= '0;
        r_drain <= 1'b0;
      end
      if (w_issue) begin
        r_w <= r_w + 1'b1;
        if (!w_last_issue) begin
          if (r_c == C_W'(NUM_CH - 1)) begin
            r_c <= '0;
            r_a <= r_a + 1'b1;
          end else begin
            r_c <= r_c + 1'b1;
          end
        end
      end
      if (r_state == S_DRAIN) r_drain <= 1'b1;
      if (w_accept && !w_last_neuron) r_n <= r_n + 1'b1;
    end
  end

  // p1: feature and weight arrive; channel select is the issue channel delayed one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      r_bias_p1 <= 1'b0;
      r_ch_p1   <= '0;
    end else begin
      vld_p1    <= w_issue;
      vld_p2    <= vld_p1;
      r_bias_p1 <= (r_state == S_BIAS);
      r_ch_p1   <= w_issue ? r_c : '0;
    end
  end

  // p2: registered product
  always_ff @(posedge clk) begin
    if (vld_p1) r_prod_p2 <= $signed(feat_in) * $signed(w_data);
  end

  assign w_acc_nxt = r_acc + {{(ACC_W-2*DATA_W){r_prod_p2[2*DATA_W-1]}}, r_prod_p2};

  // Accumulate; the result is taken from the final sum on the edge that enters OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
    end else begin
      if (r_bias_p1)
        r_acc <= {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data};
      else if (vld_p2)
        r_acc <= w_acc_nxt;
      if (r_state == S_DRAIN && r_drain) begin
        r_out_data <= sat_relu(w_acc_nxt);
        r_out_idx  <= r_n;
      end
    end
  end

  assign bram_en   = w_issue;
  assign bram_addr = 11'(r_a);
  assign ch_sel    = 6'(r_ch_p1);
  assign w_addr    = r_w;
  assign b_addr    = r_n;
  assign out_valid = (r_state == S_OUT);
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
